// File: rtl/burst_latency_mem.sv
// Byte-addressable backing memory: fixed latency, byte-enabled writes, burst reads.
// Define BURST_MEM_CWF_EN to return the requested word first in a burst.
module burst_latency_mem #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 10,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_burst,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic                    resp_last,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   resp_addr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BW     = $clog2(BYTES);
  localparam int WAW    = ADDR_WIDTH - BW;
  localparam int CW     = $clog2(LATENCY) + 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  typedef logic [WAW-1:0] word_t;
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  localparam word_t WMASK = word_t'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2**WAW];

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic                r_we, r_burst;
  word_t               r_wa;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]    r_be;

  logic  issue, last, burst_rd, accept;
  word_t word, block, start;

  logic unused_addr;
  assign unused_addr = ^req_addr[BW-1:0];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign burst_rd  = r_burst && !r_we;
  assign block     = r_wa & ~WMASK;
`ifdef BURST_MEM_CWF_EN
  assign start = r_wa & WMASK;
`else
  assign start = '0;
`endif

  // State, latency counter and beat index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      beat  <= beat_nx;
    end
  end

  // Capture all request fields at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_wa    <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (accept) begin
      r_we    <= req_we;
      r_burst <= req_burst;
      r_wa    <= req_addr[ADDR_WIDTH-1:BW];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Next state and beat selection; the word offset wraps inside the block
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    beat_nx  = beat;
    issue    = 1'b0;
    last     = 1'b0;
    word     = r_wa;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = WAIT;
          cnt_nx   = CW'(LATENCY - 1);
          beat_nx  = '0;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          issue = 1'b1;
          if (burst_rd) word = block | start;
          if (burst_rd && BURST_LEN > 1) begin
            state_nx = XFER;
            beat_nx  = BEAT_W'(1);
          end else begin
            last     = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      XFER: begin
        issue = 1'b1;
        word  = block | ((start + word_t'(beat)) & WMASK);
        last  = (beat == BEAT_W'(BURST_LEN - 1));
        if (last) state_nx = IDLE;
        else      beat_nx  = beat + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Register one response beat per issuing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_rdata <= '0;
      resp_addr  <= '0;
    end else begin
      resp_valid <= issue;
      resp_last  <= issue && last;
      if (issue) begin
        resp_addr  <= ADDR_WIDTH'(word) << BW;
        resp_rdata <= r_we ? '0 : mem[word];
      end
    end
  end

  // Commit enabled write bytes at the response edge; contents are not reset
  always_ff @(posedge clk) begin
    if (issue && r_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) mem[r_wa][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule
